// File: rtl/fifo_pkt_framer.sv
// Drains bytes from a synchronous FIFO into a payload buffer and emits them as
// SOF/LEN/payload/checksum frames on a registered valid/ready byte stream.
module fifo_pkt_framer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned TIMEOUT = 16,
  parameter logic [7:0]  SOF     = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          r_en,
  input  logic [DW-1:0] r_data,
  input  logic          empty,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [7:0]    m_data,
  output logic          m_last,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    COLLECT,
    SEND_SOF,
    SEND_LEN,
    SEND_PAY,
    SEND_CSUM
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          rd_pend_q;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic [7:0]    m_data_q, m_data_d;
  logic [7:0]    pay_q [MAX_LEN];

  logic tmo_hit, hs, room, capture;

  assign tmo_hit = (timer_q == TW'(TIMEOUT));
  assign hs      = m_valid_q && m_ready;
  // In-flight read counts against capacity so the buffer can never overflow.
  assign room    = (9'(cnt_q) + 9'(rd_pend_q)) < 9'(MAX_LEN);
  assign r_en    = (state_q == COLLECT) && !empty && !tmo_hit && room;
  assign capture = (state_q == COLLECT) && rd_pend_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    timer_d = timer_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      COLLECT: begin
        if (capture) begin
          cnt_d   = cnt_q + 8'd1;
          csum_d  = csum_q + r_data[7:0];
          timer_d = '0;
        end else if (cnt_q != 8'd0 && !tmo_hit) begin
          timer_d = timer_q + TW'(1);
        end
        if (cnt_q == 8'(MAX_LEN) || (tmo_hit && !rd_pend_q)) begin
          state_d = SEND_SOF;
          idx_d   = '0;
        end
      end
      SEND_SOF: if (hs) state_d = SEND_LEN;
      SEND_LEN: if (hs) state_d = SEND_PAY;
      SEND_PAY: begin
        if (hs) begin
          if (idx_q == cnt_q - 8'd1) state_d = SEND_CSUM;
          else                       idx_d   = idx_q + 8'd1;
        end
      end
      SEND_CSUM: begin
        if (hs) begin
          state_d = COLLECT;
          fcnt_d  = fcnt_q + 16'd1;
          cnt_d   = '0;
          csum_d  = '0;
          timer_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Output registers are loaded from next-state so they hold while stalled.
  always_comb begin
    m_valid_d = (state_d != COLLECT);
    m_last_d  = (state_d == SEND_CSUM);
    m_data_d  = '0;
    unique case (state_d)
      SEND_SOF:  m_data_d = SOF;
      SEND_LEN:  m_data_d = cnt_d;
      SEND_PAY:  m_data_d = pay_q[idx_d[AW-1:0]];
      SEND_CSUM: m_data_d = csum_d;
      default:   m_data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      timer_q   <= '0;
      fcnt_q    <= '0;
      rd_pend_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      timer_q   <= timer_d;
      fcnt_q    <= fcnt_d;
      rd_pend_q <= r_en;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) pay_q[cnt_q[AW-1:0]] <= r_data[7:0];
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign busy      = (state_q != COLLECT);
  assign frame_cnt = fcnt_q;

endmodule
